// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the unified-memory arbiter (mem_arbiter).
package mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        BUSY_I = 2'd1,
        BUSY_D = 2'd2,
        RESP   = 2'd3
    } arb_state_t;

    typedef enum logic {
        INSTR = 1'b0,
        DATA  = 1'b1
    } owner_t;

    localparam int WAIT_MAX_DEF = 16;
    localparam int TIMER_W      = $clog2(WAIT_MAX_DEF + 1);

    function automatic int timer_width(input int wait_max);
        return $clog2(wait_max + 1);
    endfunction

endpackage

// File: rtl/mem_arb_timer.sv
// Access watchdog for mem_arbiter: counts BUSY cycles from zero and flags the
// last cycle the memory is allowed before the access is abandoned.
module mem_arb_timer
    import mem_arb_pkg::*;
#(
    parameter int WAIT_MAX = WAIT_MAX_DEF,
    parameter int TW       = timer_width(WAIT_MAX)
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic count,
    output logic expired
);

    localparam logic [TW-1:0] LAST = TW'(WAIT_MAX - 1);

    logic [TW-1:0] count_r;

    // Cycle counter; saturates on the last permitted cycle.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count_r <= {TW{1'b0}};
        end else if (clear) begin
            count_r <= {TW{1'b0}};
        end else if (count && (count_r != LAST)) begin
            count_r <= count_r + TW'(1);
        end else begin
            count_r <= count_r;
        end
    end

    assign expired = (count_r == LAST);

endmodule

// File: rtl/mem_arbiter.sv
// Arbiter sharing one single-ported memory between the CPU fetch and data ports.
// Build option MEM_ARB_RR_EN: round-robin on simultaneous requests; otherwise data wins.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int WIDTH    = 32,
    parameter int WAIT_MAX = WAIT_MAX_DEF
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             iReq,
    input  logic [WIDTH-1:0] iAddr,
    output logic [WIDTH-1:0] iRdata,
    output logic             iAck,
    input  logic             dReq,
    input  logic             dWe,
    input  logic [WIDTH-1:0] dAddr,
    input  logic [WIDTH-1:0] dWdata,
    output logic [WIDTH-1:0] dRdata,
    output logic             dAck,
    output logic             busErr,
    output logic             memReq,
    output logic             memWe,
    output logic [WIDTH-1:0] memAddr,
    output logic [WIDTH-1:0] memWdata,
    input  logic [WIDTH-1:0] memRdata,
    input  logic             memReady
);

    localparam logic [WIDTH-1:0] ZERO_W = {WIDTH{1'b0}};

    arb_state_t       state_r,      state_nx;
    owner_t           owner_r,      owner_nx;
    owner_t           last_owner_r, last_owner_nx;
    logic             mem_req_r,    mem_req_nx;
    logic             mem_we_r,     mem_we_nx;
    logic [WIDTH-1:0] mem_addr_r,   mem_addr_nx;
    logic [WIDTH-1:0] mem_wdata_r,  mem_wdata_nx;
    logic [WIDTH-1:0] i_rdata_r,    i_rdata_nx;
    logic [WIDTH-1:0] d_rdata_r,    d_rdata_nx;
    logic             i_ack_r,      i_ack_nx;
    logic             d_ack_r,      d_ack_nx;
    logic             bus_err_r,    bus_err_nx;

    logic             timer_clear_s;
    logic             timer_count_s;
    logic             timer_expired_s;
    logic             prefer_data_s;
    logic             grant_data_s;
    logic [WIDTH-1:0] resp_data_s;

`ifdef MEM_ARB_RR_EN
    assign prefer_data_s = (last_owner_r == INSTR);
`else
    assign prefer_data_s = 1'b1;
`endif

    // A lone requester always wins; on a tie the preference decides.
    assign grant_data_s = dReq && (!iReq || prefer_data_s);

    mem_arb_timer #(
        .WAIT_MAX (WAIT_MAX)
    ) u_timer (
        .clk     (clk),
        .reset   (reset),
        .clear   (timer_clear_s),
        .count   (timer_count_s),
        .expired (timer_expired_s)
    );

    // Next-state and next-output logic for the arbitration FSM.
    always_comb begin
        state_nx      = state_r;
        owner_nx      = owner_r;
        last_owner_nx = last_owner_r;
        mem_req_nx    = mem_req_r;
        mem_we_nx     = mem_we_r;
        mem_addr_nx   = mem_addr_r;
        mem_wdata_nx  = mem_wdata_r;
        i_rdata_nx    = i_rdata_r;
        d_rdata_nx    = d_rdata_r;
        i_ack_nx      = 1'b0;
        d_ack_nx      = 1'b0;
        bus_err_nx    = 1'b0;
        timer_clear_s = 1'b0;
        timer_count_s = 1'b0;
        resp_data_s   = ZERO_W;

        case (state_r)
            IDLE: begin
                timer_clear_s = 1'b1;
                if (grant_data_s) begin
                    state_nx     = BUSY_D;
                    owner_nx     = DATA;
                    mem_req_nx   = 1'b1;
                    mem_we_nx    = dWe;
                    mem_addr_nx  = dAddr;
                    mem_wdata_nx = dWdata;
                end else if (iReq) begin
                    state_nx     = BUSY_I;
                    owner_nx     = INSTR;
                    mem_req_nx   = 1'b1;
                    mem_we_nx    = 1'b0;
                    mem_addr_nx  = iAddr;
                    mem_wdata_nx = ZERO_W;
                end else begin
                    state_nx     = IDLE;
                end
            end

            BUSY_I, BUSY_D: begin
                // memReady beats a coinciding timeout; stores return zero data.
                if (memReady || timer_expired_s) begin
                    state_nx    = RESP;
                    mem_req_nx  = 1'b0;
                    mem_we_nx   = 1'b0;
                    bus_err_nx  = !memReady;
                    resp_data_s = (memReady && !mem_we_r) ? memRdata : ZERO_W;
                    if (state_r == BUSY_D) begin
                        d_ack_nx   = 1'b1;
                        d_rdata_nx = resp_data_s;
                    end else begin
                        i_ack_nx   = 1'b1;
                        i_rdata_nx = resp_data_s;
                    end
                end else begin
                    timer_count_s = 1'b1;
                end
            end

            RESP: begin
                state_nx      = IDLE;
                last_owner_nx = owner_r;
            end

            default: begin
                state_nx   = IDLE;
                mem_req_nx = 1'b0;
                mem_we_nx  = 1'b0;
            end
        endcase
    end

    // FSM state register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_nx;
        end
    end

    // Memory-bus, response and ownership registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            owner_r      <= INSTR;
            last_owner_r <= INSTR;
            mem_req_r    <= 1'b0;
            mem_we_r     <= 1'b0;
            mem_addr_r   <= ZERO_W;
            mem_wdata_r  <= ZERO_W;
            i_rdata_r    <= ZERO_W;
            d_rdata_r    <= ZERO_W;
            i_ack_r      <= 1'b0;
            d_ack_r      <= 1'b0;
            bus_err_r    <= 1'b0;
        end else begin
            owner_r      <= owner_nx;
            last_owner_r <= last_owner_nx;
            mem_req_r    <= mem_req_nx;
            mem_we_r     <= mem_we_nx;
            mem_addr_r   <= mem_addr_nx;
            mem_wdata_r  <= mem_wdata_nx;
            i_rdata_r    <= i_rdata_nx;
            d_rdata_r    <= d_rdata_nx;
            i_ack_r      <= i_ack_nx;
            d_ack_r      <= d_ack_nx;
            bus_err_r    <= bus_err_nx;
        end
    end

    assign memReq   = mem_req_r;
    assign memWe    = mem_we_r;
    assign memAddr  = mem_addr_r;
    assign memWdata = mem_wdata_r;
    assign iRdata   = i_rdata_r;
    assign dRdata   = d_rdata_r;
    assign iAck     = i_ack_r;
    assign dAck     = d_ack_r;
    assign busErr   = bus_err_r;

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed cases with literal expectations
// plus randomized traffic compared every cycle against a transaction-level model.
module tb_mem_arbiter;

    localparam int WIDTH    = 32;
    localparam int WAIT_MAX = 16;

    logic             clk = 1'b0;
    logic             reset;
    logic             iReq, dReq, dWe, memReady;
    logic [WIDTH-1:0] iAddr, dAddr, dWdata, memRdata;
    logic [WIDTH-1:0] iRdata, dRdata, memAddr, memWdata;
    logic             iAck, dAck, busErr, memReq, memWe;

    int n_chk  = 0;
    int n_fail = 0;

    // Model: expected outputs plus the facts of the access in flight.
    logic             e_memReq, e_memWe, e_iAck, e_dAck, e_busErr;
    logic [WIDTH-1:0] e_memAddr, e_memWdata, e_iRdata, e_dRdata;
    bit               m_resp, m_port, m_last;
    int               cyc, m_start;

    // Memory responder and directed-test scratch.
    int               mem_cnt, mem_delay, n_busy;
    logic [WIDTH-1:0] mem_data, exp_addr;
    bit               mem_rand, spurious;

    always #5 clk = ~clk;

    mem_arbiter #(.WIDTH(WIDTH), .WAIT_MAX(WAIT_MAX)) dut (
        .clk(clk), .reset(reset),
        .iReq(iReq), .iAddr(iAddr), .iRdata(iRdata), .iAck(iAck),
        .dReq(dReq), .dWe(dWe), .dAddr(dAddr), .dWdata(dWdata),
        .dRdata(dRdata), .dAck(dAck), .busErr(busErr),
        .memReq(memReq), .memWe(memWe), .memAddr(memAddr), .memWdata(memWdata),
        .memRdata(memRdata), .memReady(memReady)
    );

    task automatic check_bit(input string name, input logic act, input logic exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b, expected %b at t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic check_word(input string name, input logic [WIDTH-1:0] act, input logic [WIDTH-1:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h at t=%0t", name, act, exp, $time);
        end
    endtask

    function automatic bit prefer_data();
`ifdef MEM_ARB_RR_EN
        return (m_last == 1'b0);
`else
        return 1'b1;
`endif
    endfunction

    function automatic void model_reset();
        e_memReq   = 1'b0; e_memWe = 1'b0; e_iAck = 1'b0; e_dAck = 1'b0; e_busErr = 1'b0;
        e_memAddr  = {WIDTH{1'b0}}; e_memWdata = {WIDTH{1'b0}};
        e_iRdata   = {WIDTH{1'b0}}; e_dRdata   = {WIDTH{1'b0}};
        m_resp     = 1'b0; m_last = 1'b0;
    endfunction

    // One clock edge of the model: idle -> grant, access -> response, response -> idle.
    function automatic void model_edge();
        logic [WIDTH-1:0] data;
        bit               to_data;
        cyc++;
        if (!reset) begin
            model_reset();
            return;
        end
        if (m_resp) begin
            m_resp = 1'b0; e_iAck = 1'b0; e_dAck = 1'b0; e_busErr = 1'b0;
            m_last = m_port;
        end else if (e_memReq) begin
            if (memReady || (cyc - m_start == WAIT_MAX)) begin
                data     = (memReady && !e_memWe) ? memRdata : {WIDTH{1'b0}};
                e_busErr = !memReady;
                e_memReq = 1'b0;
                e_memWe  = 1'b0;
                m_resp   = 1'b1;
                if (m_port) begin e_dAck = 1'b1; e_dRdata = data; end
                else        begin e_iAck = 1'b1; e_iRdata = data; end
            end
        end else if (iReq || dReq) begin
            to_data    = dReq && (!iReq || prefer_data());
            m_port     = to_data;
            m_start    = cyc;
            e_memReq   = 1'b1;
            e_memWe    = to_data ? dWe : 1'b0;
            e_memAddr  = to_data ? dAddr : iAddr;
            e_memWdata = to_data ? dWdata : {WIDTH{1'b0}};
        end
    endfunction

    // Memory model: answers after mem_delay cycles of memReq (1000 = never).
    function automatic void mem_drive();
        if (e_memReq) begin
            memReady = (mem_cnt == mem_delay);
            memRdata = memReady ? mem_data : $urandom();
            mem_cnt++;
        end else begin
            mem_cnt = 0;
            if (mem_rand) begin
                mem_delay = ($urandom_range(0, 11) == 0) ? 1000 : int'($urandom_range(0, 4));
                mem_data  = $urandom();
            end
            memReady = spurious && ($urandom_range(0, 5) == 0);
            memRdata = $urandom();
        end
    endfunction

    // Random requesters: raise at will, hold until acked, then drop or reissue.
    function automatic void req_drive();
        if (!iReq) begin
            if ($urandom_range(0, 2) == 0) begin
                iReq  = 1'b1;
                iAddr = $urandom() & 32'hFFFF_FFFC;
            end
        end else if (e_iAck) begin
            if ($urandom_range(0, 3) == 0) iAddr = $urandom() & 32'hFFFF_FFFC;
            else iReq = 1'b0;
        end
        if (!dReq) begin
            if ($urandom_range(0, 2) == 0) begin
                dReq   = 1'b1;
                dWe    = 1'($urandom_range(0, 1));
                dAddr  = $urandom() & 32'hFFFF_FFFC;
                dWdata = $urandom();
            end
        end else if (e_dAck) begin
            if ($urandom_range(0, 3) == 0) begin
                dWe    = 1'($urandom_range(0, 1));
                dAddr  = $urandom() & 32'hFFFF_FFFC;
                dWdata = $urandom();
            end else begin
                dReq = 1'b0;
            end
        end
    endfunction

    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
        mem_drive();
    endtask

    // Every-cycle comparison of the DUT against the model.
    always @(negedge clk) begin
        check_bit("memReq", memReq, e_memReq);
        check_bit("iAck", iAck, e_iAck);
        check_bit("dAck", dAck, e_dAck);
        check_bit("busErr", busErr, e_busErr);
        check_word("iRdata", iRdata, e_iRdata);
        check_word("dRdata", dRdata, e_dRdata);
        check_bit("ack_exclusive", iAck & dAck, 1'b0);
        if (e_memReq) begin
            check_word("memAddr", memAddr, e_memAddr);
            check_bit("memWe", memWe, e_memWe);
            if (e_memWe) check_word("memWdata", memWdata, e_memWdata);
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: time limit reached before end of test");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset = 1'b1; iReq = 1'b0; dReq = 1'b0; dWe = 1'b0;
        iAddr = '0; dAddr = '0; dWdata = '0; memRdata = '0; memReady = 1'b0;
        mem_rand = 1'b0; spurious = 1'b0; mem_delay = 0; mem_cnt = 0; mem_data = '0;
        cyc = 0; m_start = 0; m_port = 1'b0;
        model_reset();
        #2 reset = 1'b0;
        tick(); tick();
        check_bit("rst_memReq", memReq, 1'b0);
        check_bit("rst_memWe", memWe, 1'b0);
        check_bit("rst_acks", iAck | dAck | busErr, 1'b0);
        check_word("rst_memAddr", memAddr, 32'h0);
        check_word("rst_memWdata", memWdata, 32'h0);
        check_word("rst_rdata", iRdata | dRdata, 32'h0);
        #2 reset = 1'b1;
        tick();

        // Fetch only, minimum latency.
        iReq = 1'b1; iAddr = 32'h40; mem_delay = 0; mem_data = 32'h8C22_0004;
        tick();
        check_bit("t1_memReq", memReq, 1'b1);
        check_word("t1_memAddr", memAddr, 32'h40);
        check_bit("t1_memWe", memWe, 1'b0);
        tick();
        check_bit("t1_iAck", iAck, 1'b1);
        check_word("t1_iRdata", iRdata, 32'h8C22_0004);
        check_bit("t1_busErr", busErr, 1'b0);
        check_bit("t1_memReq_drop", memReq, 1'b0);
        iReq = 1'b0;
        tick();
        check_bit("t1_ack_one_cycle", iAck, 1'b0);

        // Simultaneous requests: data first, then the held fetch.
        iReq = 1'b1; iAddr = 32'h44; dReq = 1'b1; dWe = 1'b0; dAddr = 32'h100; mem_data = 32'h1111_0000;
        tick();
        check_word("t2_first_addr", memAddr, 32'h100);
        tick();
        check_bit("t2_dAck", dAck, 1'b1);
        check_bit("t2_no_iAck", iAck, 1'b0);
        check_word("t2_dRdata", dRdata, 32'h1111_0000);
        dReq = 1'b0; mem_data = 32'h2222_0000;
        tick();
        tick();
        check_word("t2_second_addr", memAddr, 32'h44);
        check_bit("t2_second_we", memWe, 1'b0);
        tick();
        check_bit("t2_iAck", iAck, 1'b1);
        check_bit("t2_no_dAck", dAck, 1'b0);
        check_word("t2_iRdata", iRdata, 32'h2222_0000);
        iReq = 1'b0;
        tick();

        // Both held for four transactions; last owner is the fetch port here.
        iReq = 1'b1; dReq = 1'b1; dWe = 1'b0; iAddr = 32'h1000; dAddr = 32'h2000;
        for (int t = 0; t < 4; t++) begin
            mem_data = 32'hA5A5_0000 | 32'(t + 1);
            tick();
`ifdef MEM_ARB_RR_EN
            exp_addr = (t % 2 == 0) ? 32'h2000 : 32'h1000;
`else
            exp_addr = 32'h2000;
`endif
            check_word("t3_grant_order", memAddr, exp_addr);
            tick();
            check_bit("t3_ack_port", dAck, (exp_addr == 32'h2000) ? 1'b1 : 1'b0);
            if (t == 3) begin iReq = 1'b0; dReq = 1'b0; end
            tick();
        end

        // Load with a memory that never answers.
        dReq = 1'b1; dWe = 1'b0; dAddr = 32'h300; mem_delay = 1000;
        tick();
        n_busy = 0;
        for (int k = 0; k < 40 && !dAck; k++) begin
            if (memReq) n_busy++;
            tick();
        end
        check_word("t5_busy_cycles", n_busy, 32'd16);
        check_bit("t5_dAck", dAck, 1'b1);
        check_bit("t5_busErr", busErr, 1'b1);
        check_word("t5_dRdata", dRdata, 32'h0);
        dReq = 1'b0; mem_delay = 0;
        tick();
        check_bit("t5_busErr_one_cycle", busErr, 1'b0);

        // Store answered on the fourth memReq cycle.
        dReq = 1'b1; dWe = 1'b1; dAddr = 32'h200; dWdata = 32'hDEAD_BEEF; mem_delay = 3; mem_data = 32'h1234_5678;
        tick();
        for (int k = 0; k < 4; k++) begin
            check_bit("t4_memReq", memReq, 1'b1);
            check_bit("t4_memWe", memWe, 1'b1);
            check_word("t4_memAddr", memAddr, 32'h200);
            check_word("t4_memWdata", memWdata, 32'hDEAD_BEEF);
            tick();
        end
        check_bit("t4_dAck", dAck, 1'b1);
        check_word("t4_dRdata", dRdata, 32'h0);
        check_bit("t4_busErr", busErr, 1'b0);
        dReq = 1'b0; dWe = 1'b0; mem_delay = 0;
        tick();

        // Asynchronous reset in the middle of a data access, fetch pending.
        dReq = 1'b1; dWe = 1'b1; dAddr = 32'h400; dWdata = 32'h0BAD_F00D; mem_delay = 1000;
        tick();
        iReq = 1'b1; iAddr = 32'h500;
        tick(); tick();
        #2 reset = 1'b0;
        model_reset();
        dReq = 1'b0; dWe = 1'b0;
        #1;
        check_bit("t6_memReq_async", memReq, 1'b0);
        check_bit("t6_memWe_async", memWe, 1'b0);
        check_word("t6_memAddr_async", memAddr, 32'h0);
        check_word("t6_memWdata_async", memWdata, 32'h0);
        tick(); tick();
        check_bit("t6_no_ack", dAck | iAck, 1'b0);
        #2 reset = 1'b1; mem_delay = 0; mem_data = 32'h3333_0000;
        tick();
        check_bit("t6_fetch_granted", memReq, 1'b1);
        check_word("t6_fetch_addr", memAddr, 32'h500);
        tick();
        check_bit("t6_iAck", iAck, 1'b1);
        check_word("t6_iRdata", iRdata, 32'h3333_0000);
        iReq = 1'b0;
        tick();

        // Random traffic with random latencies, timeouts and stray memReady.
        mem_rand = 1'b1; spurious = 1'b1;
        for (int c = 0; c < 3000; c++) begin
            req_drive();
            tick();
        end
        for (int c = 0; c < 300; c++) begin
            if (iReq && e_iAck) iReq = 1'b0;
            if (dReq && e_dAck) dReq = 1'b0;
            if (!iReq && !dReq && !e_memReq && !m_resp) break;
            tick();
        end
        check_bit("drain_idle", memReq | iReq | dReq, 1'b0);
        tick(); tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
